// File: rtl/median_seq.sv
// Sequencer for a compare-exchange median core: loads a burst, runs the max-discard
// schedule and pulses DSO when the core output holds the median.

module median_seq #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUMBER = 9
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    output logic             BUSY,
    output logic             ERR
);

    localparam int unsigned CW = $clog2(NUMBER) + 1;
    localparam logic [CW-1:0] LastIdx  = CW'(NUMBER - 1);
    localparam logic [CW-1:0] LastPass = CW'((NUMBER - 1) / 2 - 1);

    typedef enum logic [2:0] {StIdle, StLoad, StPass, StFinal, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   load_cnt_q, load_cnt_d;
    logic [CW-1:0]   pass_q, pass_d;
    logic [CW-1:0]   step_q, step_d;
    logic            med_dsi;
    logic            med_byp;

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        pass_d     = pass_q;
        step_d     = step_q;
        med_dsi    = 1'b0;
        med_byp    = 1'b1;
        unique case (state_q)
            StIdle, StDone: begin
                med_dsi = DSI;
                if (DSI) begin
                    state_d    = StLoad;
                    load_cnt_d = CW'(1);
                end else begin
                    state_d    = StIdle;
                    load_cnt_d = '0;
                end
            end
            StLoad: begin
                med_dsi = 1'b1;
                if (!DSI) begin
                    state_d    = StIdle;
                    load_cnt_d = '0;
                end else if (load_cnt_q == LastIdx) begin
                    state_d    = StPass;
                    load_cnt_d = '0;
                    pass_d     = '0;
                    step_d     = '0;
                end else begin
                    load_cnt_d = load_cnt_q + CW'(1);
                end
            end
            StPass: begin
                // Pass k compares for NUMBER-1-k steps, then rotates the held max out.
                med_byp = (step_q >= (LastIdx - pass_q));
                if (step_q == LastIdx) begin
                    step_d = '0;
                    if (pass_q == LastPass) begin
                        state_d = StFinal;
                        pass_d  = '0;
                    end else begin
                        pass_d = pass_q + CW'(1);
                    end
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            StFinal: begin
                med_byp = 1'b0;
                if (step_q == LastPass) begin
                    state_d = StDone;
                    step_d  = '0;
                end else begin
                    step_d = step_q + CW'(1);
                end
            end
            default: begin
                state_d    = StIdle;
                load_cnt_d = '0;
                pass_d     = '0;
                step_d     = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= StIdle;
            load_cnt_q <= '0;
            pass_q     <= '0;
            step_q     <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            pass_q     <= pass_d;
            step_q     <= step_d;
        end
    end

    // ERR and the cycle-0 BUSY depend on the live strobe, so they are decoded directly.
    always_comb begin
        DSO  = (state_q == StDone);
        ERR  = (state_q == StLoad) && !DSI;
        BUSY = (state_q != StIdle) || DSI;
    end

    median_med #(
        .WIDTH (WIDTH),
        .NUMBER(NUMBER)
    ) u_med (
        .CLK(CLK),
        .DI (DI),
        .DSI(med_dsi),
        .BYP(med_byp),
        .DO (DO)
    );

endmodule

// Ring of NUMBER registers; R[NUMBER-1] is the holding cell that keeps the larger
// of itself and R[NUMBER-2] on a compare step and passes its loser back to R[0].
module median_med #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned NUMBER = 9
) (
    input  logic             CLK,
    input  logic [WIDTH-1:0] DI,
    input  logic             DSI,
    input  logic             BYP,
    output logic [WIDTH-1:0] DO
);

    logic [WIDTH-1:0] r_q [NUMBER];
    logic [WIDTH-1:0] r_d [NUMBER];
    logic [WIDTH-1:0] hold;
    logic [WIDTH-1:0] cand;
    logic             cand_gt;

    always_comb begin
        hold    = r_q[NUMBER-1];
        cand    = r_q[NUMBER-2];
        cand_gt = (cand > hold);
        for (int i = 1; i < NUMBER; i++) begin
            r_d[i] = r_q[i-1];
        end
        r_d[0] = hold;
        if (DSI) begin
            r_d[0] = DI;
        end else if (!BYP) begin
            r_d[0]        = cand_gt ? hold : cand;
            r_d[NUMBER-1] = cand_gt ? cand : hold;
        end
    end

    always_ff @(posedge CLK) begin
        r_q <= r_d;
    end

    assign DO = r_q[NUMBER-1];

endmodule

// File: tb/tb_median_seq.sv
// Directed bench for median_seq with NUMBER=9: schedule timing, medians, abort and reset.

module tb_median_seq;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] DI;
    logic       DSI;
    logic [7:0] DO;
    logic       DSO;
    logic       BUSY;
    logic       ERR;

    int checks = 0;
    int errors = 0;

    logic       s_dso, s_busy, s_err;
    logic [7:0] s_do;

    logic [7:0] v_up  [9];
    logic [7:0] v_dn  [9];
    logic [7:0] v_blk [9];
    logic [7:0] v_alt [9];
    logic [7:0] v_ten [9];
    logic [7:0] v_mix [9];
    logic [7:0] v_rst [9];
    logic [7:0] v_b2b [9];

    median_seq #(
        .WIDTH (8),
        .NUMBER(9)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .DI  (DI),
        .DSI (DSI),
        .DO  (DO),
        .DSO (DSO),
        .BUSY(BUSY),
        .ERR (ERR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample outputs mid-cycle, advance past the edge.
    task automatic drive(input logic [7:0] di, input logic dsi);
        DI  = di;
        DSI = dsi;
        @(negedge CLK);
        s_dso  = DSO;
        s_busy = BUSY;
        s_err  = ERR;
        s_do   = DO;
        @(posedge CLK);
        #1;
    endtask

    // Cycles 0..49 of one burst; cycle 49 drives next_di/next_dsi.
    task automatic run_burst(input string tag, input logic [7:0] v [9], input logic [7:0] med,
                             input bit noise, input bit skip_first, input logic next_dsi,
                             input logic [7:0] next_di);
        int early    = 0;
        int busy_low = 0;
        for (int c = (skip_first ? 1 : 0); c < 49; c++) begin
            if (c < 9) drive(v[c], 1'b1);
            else       drive(noise ? 8'($urandom) : 8'd0, noise);
            if (c == 0) chk({tag, "_busy_c0"}, 32'(s_busy), 32'd1);
            early    += int'(s_dso);
            busy_low += int'(!s_busy);
        end
        drive(next_di, next_dsi);
        chk({tag, "_dso_c49"}, 32'(s_dso), 32'd1);
        chk({tag, "_do_c49"}, 32'(s_do), 32'(med));
        chk({tag, "_busy_c49"}, 32'(s_busy), 32'd1);
        chk({tag, "_no_early_dso"}, 32'(early), 32'd0);
        chk({tag, "_busy_held"}, 32'(busy_low), 32'd0);
    endtask

    initial begin
        int n_dso;
        int n_err;
        v_up  = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        v_dn  = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        v_blk = '{8'd7, 8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd255, 8'd255, 8'd255};
        v_alt = '{8'd3, 8'd200, 8'd3, 8'd200, 8'd3, 8'd200, 8'd3, 8'd200, 8'd3};
        v_ten = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90};
        v_mix = '{8'd5, 8'd1, 8'd4, 8'd2, 8'd3, 8'd9, 8'd8, 8'd7, 8'd6};
        v_rst = '{8'd40, 8'd80, 8'd10, 8'd90, 8'd60, 8'd30, 8'd70, 8'd20, 8'd50};
        v_b2b = '{8'd200, 8'd100, 8'd150, 8'd50, 8'd250, 8'd0, 8'd175, 8'd25, 8'd125};

        RST = 1'b1;
        DI  = '0;
        DSI = 1'b0;
        drive(8'd0, 1'b0);
        drive(8'd0, 1'b0);
        RST = 1'b0;
        drive(8'd0, 1'b0);
        chk("rst_dso", 32'(s_dso), 32'd0);
        chk("rst_busy", 32'(s_busy), 32'd0);
        chk("rst_err", 32'(s_err), 32'd0);

        run_burst("up", v_up, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);
        chk("up_busy_c50", 32'(s_busy), 32'd0);
        chk("up_dso_c50", 32'(s_dso), 32'd0);

        run_burst("down", v_dn, 8'd5, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);
        run_burst("blocks", v_blk, 8'd7, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);
        run_burst("alt", v_alt, 8'd3, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);

        // Abort after five samples.
        for (int c = 0; c < 5; c++) drive(8'(c + 1), 1'b1);
        drive(8'd0, 1'b0);
        chk("abort_err_c5", 32'(s_err), 32'd1);
        drive(8'd0, 1'b0);
        chk("abort_err_c6", 32'(s_err), 32'd0);
        chk("abort_busy_c6", 32'(s_busy), 32'd0);
        n_dso = 0;
        n_err = 0;
        for (int c = 0; c < 55; c++) begin
            drive(8'd0, 1'b0);
            n_dso += int'(s_dso);
            n_err += int'(s_err);
        end
        chk("abort_no_dso", 32'(n_dso), 32'd0);
        chk("abort_no_err", 32'(n_err), 32'd0);
        run_burst("tens", v_ten, 8'd50, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);

        run_burst("noise", v_mix, 8'd5, 1'b1, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);
        chk("noise_busy_c50", 32'(s_busy), 32'd0);

        // Reset in processing cycle 30.
        for (int c = 0; c < 9; c++) drive(v_up[c], 1'b1);
        for (int c = 9; c < 30; c++) drive(8'd0, 1'b0);
        RST = 1'b1;
        drive(8'd0, 1'b0);
        RST = 1'b0;
        drive(8'd0, 1'b0);
        chk("rst_mid_dso", 32'(s_dso), 32'd0);
        chk("rst_mid_busy", 32'(s_busy), 32'd0);
        chk("rst_mid_err", 32'(s_err), 32'd0);
        n_dso = 0;
        n_err = 0;
        for (int c = 0; c < 30; c++) begin
            drive(8'd0, 1'b0);
            n_dso += int'(s_dso);
            n_err += int'(s_err);
        end
        chk("rst_mid_no_dso", 32'(n_dso), 32'd0);
        chk("rst_mid_no_err", 32'(n_err), 32'd0);
        run_burst("after_rst", v_rst, 8'd50, 1'b0, 1'b0, 1'b0, 8'd0);
        drive(8'd0, 1'b0);

        // Second burst starts in the DONE cycle of the first.
        run_burst("b2b_a", v_up, 8'd5, 1'b0, 1'b0, 1'b1, v_b2b[0]);
        run_burst("b2b_b", v_b2b, 8'd125, 1'b0, 1'b1, 1'b0, 8'd0);
        drive(8'd0, 1'b0);
        chk("b2b_busy_end", 32'(s_busy), 32'd0);
        chk("b2b_dso_end", 32'(s_dso), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/median_seq.md
Name: median_seq

Overview:
- Sequencing stage that drives the 9-entry compare-exchange median core (MED).
- Accepts a burst of NUMBER samples and generates MED's DSI/BYP schedule to discard the largest values pass by pass.
- Flags the cycle where MED's DO holds the median, for the next pixel stage.
- Instantiates MED internally. Sits between the 3x3 window serializer (upstream) and the output pixel writer (downstream).

Parameters:
WIDTH, 8, sample width in bits (passed to MED)
NUMBER, 9, samples per median; must be odd and >=3 (passed to MED)

Ports:
CLK  input  1  clock, all logic on rising edge
RST  input  1  synchronous, active-high reset
DI  input  WIDTH  input sample, valid when DSI=1
DSI  input  1  sample strobe; a burst is NUMBER consecutive cycles high
DO  output  WIDTH  MED output R[NUMBER-1]; meaningful only when DSO=1
DSO  output  1  one-cycle pulse: DO holds the median of the last burst
BUSY  output  1  high from the first accepted sample until the cycle DSO is high, inclusive
ERR  output  1  one-cycle pulse: burst aborted because DSI dropped mid-load

Behaviour:
- Reset (synchronous, active-high): state=IDLE, counters=0, DSO=0, BUSY=0, ERR=0. DO is not reset (MED registers hold old data); consumers qualify DO with DSO. Reset mid-burst or mid-processing aborts silently, with no DSO and no ERR.
- Internal MED controls: med_dsi, med_byp (combinational from state/counters).
- States: IDLE, LOAD, PASS, FINAL, DONE.
- IDLE: med_dsi=DSI, med_byp=1.
  - DSI=1 -> sample 0 is shifted into MED; go to LOAD with load_cnt=1.
- LOAD: med_dsi=1, med_byp=1, load_cnt increments each cycle DSI=1.
  - When sample NUMBER-1 is captured (load_cnt=NUMBER-1 and DSI=1): go to PASS with pass=0, step=0.
  - DSI=0 in LOAD: ERR=1 for one cycle, return to IDLE. MED contents are garbage and are reloaded by the next burst.
- PASS (pass k = 0 .. (NUMBER-1)/2-1): med_dsi=0.
  - Each pass lasts NUMBER cycles.
  - Steps 0 .. NUMBER-2-k: med_byp=0 (compare).
  - Remaining k+1 steps: med_byp=1 (bypass, discards the current max).
  - After the last step of the last pass: go to FINAL, step=0.
- FINAL: med_dsi=0, med_byp=0 for (NUMBER-1)/2 cycles, then go to DONE.
- DONE: DSO=1, BUSY=1, med_dsi=DSI, med_byp=1 for one cycle.
  - DSI=1 in DONE is accepted as sample 0 of a new burst (go to LOAD, load_cnt=1). Otherwise go to IDLE.
- Latency for NUMBER=9, with sample 0 captured at the edge ending cycle 0:
  - samples occupy cycles 0-8;
  - passes occupy cycles 9-44 (4x9);
  - FINAL occupies cycles 45-48;
  - DSO=1 in cycle 49.
  - General form: NUMBER + NUMBER*(NUMBER-1)/2 + (NUMBER-1)/2 cycles after the first sample.
- DSI=1 while in PASS or FINAL is ignored (not captured, no ERR); the upstream stage must respect BUSY.
- Counter widths: clog2(NUMBER)+1 bits; no wrap-around occurs within legal ranges.

Test Plan:
- Reset, then burst DI=1,2,...,9 on 9 consecutive cycles -> BUSY rises in cycle 0, DSO=1 and DO=5 exactly in cycle 49, BUSY=0 in cycle 50.
- Burst 9,8,...,1 -> DO=5 at DSO. Burst 7,7,7,0,0,0,255,255,255 -> DO=7. Burst 3,200,3,200,3,200,3,200,3 -> DO=3.
- Burst of 5 samples, DSI low in cycle 5 -> ERR=1 in cycle 5, no DSO. A following full burst 10..90 step 10 -> DO=50.
- DSI held high during cycles 9-48 with random DI -> ignored; DSO in cycle 49 with the correct median.
- Assert RST in cycle 30 of processing -> DSO, BUSY and ERR are 0 from the next cycle. The next burst yields the correct median 49 cycles after its first sample.
- Back-to-back bursts, second starting in the DONE cycle (cycle 49) -> both medians are reported, DSO in cycles 49 and 98.
